dcache_controller: RTL and testbench



---
 rtl/dcache_controller_pkg.sv | 24 ++
 rtl/dcache_line_array.sv | 75 +++++++
 rtl/dcache_controller.sv | 185 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// dcache_controller_pkg: shared word/address widths and FSM state encoding
// for the L1 data cache. Optional statistics counters are enabled by
// defining DCACHE_STATS_EN.
`ifndef DADDR_SIZE
`define DADDR_SIZE 32
`endif
`ifndef DWORD_SIZE
`define DWORD_SIZE 4
`endif
`ifndef DWORD_SIZE_BITS
`define DWORD_SIZE_BITS 32
`endif

package dcache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dc_state_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage for the direct-mapped data
// cache. Asynchronous read, byte-masked word write, full-line fill. Only the
// valid and dirty bits are reset; tag and data are left unreset.
`ifndef DWORD_SIZE
`define DWORD_SIZE 4
`endif
`ifndef DWORD_SIZE_BITS
`define DWORD_SIZE_BITS 32
`endif

module dcache_line_array
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int BLOCK_SIZE = 16,
    parameter int TAG_BITS   = 22,
    parameter int WSEL_W     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [INDEX_BITS-1:0]        i_index,
    output logic                         o_valid,
    output logic                         o_dirty,
    output logic [TAG_BITS-1:0]          o_tag,
    output logic [BLOCK_SIZE*8-1:0]      o_line,
    input  logic                         i_word_we,
    input  logic [WSEL_W-1:0]            i_word_sel,
    input  logic [`DWORD_SIZE-1:0]       i_byte_en,
    input  logic [`DWORD_SIZE_BITS-1:0]  i_word_data,
    input  logic                         i_fill_we,
    input  logic [TAG_BITS-1:0]          i_fill_tag,
    input  logic [BLOCK_SIZE*8-1:0]      i_fill_data,
    input  logic                         i_clean
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]        r_valid;
    logic [LINES-1:0]        r_dirty;
    logic [TAG_BITS-1:0]     r_tag  [LINES];
    logic [BLOCK_SIZE*8-1:0] r_data [LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

    // Line status bits: reset invalidates every line; fill wins over a store.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clean) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    // Tag and data payload: whole-line fill or byte-masked word update.
    always_ff @(posedge clock) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_data;
        end else if (i_word_we) begin
            for (int b = 0; b < `DWORD_SIZE; b++) begin
                if (i_byte_en[b])
                    r_data[i_index][int'(i_word_sel)*32 + b*8 +: 8] <= i_word_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// behind the MEM stage. Misses stall the pipeline while the FSM writes back a
// dirty victim and fills the line. Defining DCACHE_STATS_EN adds hit, miss
// and write-back counters as extra outputs.
`ifndef DADDR_SIZE
`define DADDR_SIZE 32
`endif
`ifndef DWORD_SIZE
`define DWORD_SIZE 4
`endif
`ifndef DWORD_SIZE_BITS
`define DWORD_SIZE_BITS 32
`endif

module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ren,
    input  logic                         wen,
    input  logic [`DADDR_SIZE-1:0]       addr,
    input  logic [`DWORD_SIZE-1:0]       byte_select_vector,
    input  logic [`DWORD_SIZE_BITS-1:0]  wdata,
    output logic [`DWORD_SIZE_BITS-1:0]  rdata,
    output logic                         stall,
    output logic                         mem_ren,
    output logic                         mem_wen,
    output logic [`DADDR_SIZE-1:0]       mem_addr,
    output logic [BLOCK_SIZE*8-1:0]      mem_wdata,
    input  logic [BLOCK_SIZE*8-1:0]      mem_rdata,
    input  logic                         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]            hit_count,
    output logic [STAT_W-1:0]            miss_count,
    output logic [STAT_W-1:0]            wb_count
`endif
);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int INDEX_BITS  = $clog2(CACHE_SIZE / BLOCK_SIZE);
    localparam int TAG_BITS    = `DADDR_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int WSEL_W      = (OFFSET_BITS > 2) ? OFFSET_BITS - 2 : 1;

    dc_state_t               r_state, w_next;
    logic [TAG_BITS-1:0]     r_victim_tag;
    logic [TAG_BITS-1:0]     w_tag, w_line_tag;
    logic [INDEX_BITS-1:0]   w_index;
    logic [WSEL_W-1:0]       w_word;
    logic [BLOCK_SIZE*8-1:0] w_line;
    logic                    w_line_valid, w_line_dirty;
    logic                    w_req, w_hit, w_miss;
    logic                    w_word_we, w_fill_we, w_clean;
    logic                    w_unused_ok;

    assign w_tag       = addr[`DADDR_SIZE-1 -: TAG_BITS];
    assign w_index     = addr[OFFSET_BITS +: INDEX_BITS];
    assign w_unused_ok = &{1'b0, addr[1:0]};

    generate
        if (OFFSET_BITS > 2) begin : g_word_sel
            assign w_word = addr[2 +: WSEL_W];
        end else begin : g_single_word
            assign w_word = '0;
        end
    endgenerate

    assign w_req  = ren | wen;
    assign w_hit  = w_req & w_line_valid & (w_line_tag == w_tag);
    assign w_miss = (r_state == IDLE) & w_req & ~w_hit;

    dcache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .BLOCK_SIZE (BLOCK_SIZE),
        .TAG_BITS   (TAG_BITS),
        .WSEL_W     (WSEL_W)
    ) u_lines (
        .clock       (clock),
        .reset       (reset),
        .i_index     (w_index),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_tag       (w_line_tag),
        .o_line      (w_line),
        .i_word_we   (w_word_we),
        .i_word_sel  (w_word),
        .i_byte_en   (byte_select_vector),
        .i_word_data (wdata),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (mem_rdata),
        .i_clean     (w_clean)
    );

    // State register; the victim tag is captured when a miss is detected.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_victim_tag <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss)
                r_victim_tag <= w_line_tag;
        end
    end

    // Next state, stall, memory handshake and array write strobes.
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rdata     = '0;
        w_word_we = 1'b0;
        w_fill_we = 1'b0;
        w_clean   = 1'b0;
        case (r_state)
            IDLE: begin
                rdata     = w_line[int'(w_word)*32 +: 32];
                w_word_we = wen & w_hit;
                if (w_miss) begin
                    stall  = 1'b1;
                    w_next = (w_line_valid && w_line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {r_victim_tag, w_index, {OFFSET_BITS{1'b0}}};
                mem_wdata = w_line;
                if (mem_ready) begin
                    w_clean = 1'b1;
                    w_next  = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall    = 1'b1;
                mem_ren  = 1'b1;
                mem_addr = {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                if (mem_ready) begin
                    w_fill_we = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic              r_pending;
    logic [STAT_W-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    // Event counters; a hit that completes a previously missed request is not a hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending  <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (r_state == IDLE && w_hit) begin
                if (!r_pending)
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                r_pending <= 1'b0;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
                r_pending  <= 1'b1;
            end
            if (r_state == WRITEBACK && mem_ready)
                r_wb_cnt <= r_wb_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign wb_count   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for dcache_controller.
// A cache/memory model tracks expected line contents and per-cycle outputs;
// a negedge compare process checks every cycle. DCACHE_STATS_EN adds
// counter checks.
module tb_dcache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         ren, wen;
    logic [31:0]  addr;
    logic [3:0]   byte_select_vector;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall, mem_ren, mem_wen;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    always #5 clock = ~clock;

    dcache_controller dut (
        .clock              (clock),
        .reset              (reset),
        .ren                (ren),
        .wen                (wen),
        .addr               (addr),
        .byte_select_vector (byte_select_vector),
        .wdata              (wdata),
        .rdata              (rdata),
        .stall              (stall),
        .mem_ren            (mem_ren),
        .mem_wen            (mem_wen),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [127:0] mem_img [logic [31:0]];
    bit           m_valid [64];
    bit           m_dirty [64];
    logic [21:0]  m_tag   [64];
    logic [127:0] m_line  [64];
    int st_hit = 0, st_miss = 0, st_wb = 0;

    function automatic logic [127:0] get_mem(input logic [31:0] blk);
        logic [127:0] l;
        if (mem_img.exists(blk)) return mem_img[blk];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = (blk + w*4) ^ 32'h5A5A_0000;
        return l;
    endfunction

    // per-cycle expectations consumed by the compare process
    bit           chk_en = 0;
    bit           exp_stall, exp_mren, exp_mwen, exp_rd_chk;
    logic [31:0]  exp_maddr, exp_rdata;
    logic [127:0] exp_mwdata;

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check("mem_ren", mem_ren, exp_mren);
            check("mem_wen", mem_wen, exp_mwen);
            check("mem_addr", mem_addr, exp_maddr);
            if (exp_mwen) check("mem_wdata", mem_wdata, exp_mwdata);
            if (exp_rd_chk) check("rdata", rdata, exp_rdata);
        end
    end

    // observations from the last access
    int           last_stalls;
    logic [31:0]  last_wb_addr, last_alloc_addr, last_rdata;
    logic [127:0] last_wb_line;

    task automatic set_idle_exp();
        exp_stall = 0; exp_mren = 0; exp_mwen = 0; exp_maddr = 0; exp_rd_chk = 0;
    endtask

    task automatic sample_and_step();
        #1;
        if (stall) last_stalls++;
        if (mem_wen) begin last_wb_addr = mem_addr; last_wb_line = mem_wdata; end
        if (mem_ren) last_alloc_addr = mem_addr;
        last_rdata = rdata;
        @(posedge clock); #1;
    endtask

    task automatic do_access(input logic [31:0] a, input bit r, input bit w, input logic [3:0] be,
                             input logic [31:0] wd, input int lw, input int la);
        int idx, wsel, nw, na;
        logic [21:0] tg;
        logic [31:0] blk, vaddr;
        bit hit;
        idx  = int'((a >> 4) & 32'h3F);
        wsel = int'((a >> 2) & 32'h3);
        tg   = a[31:10];
        blk  = a & ~32'hF;
        nw   = (lw < 1) ? 1 : lw;
        na   = (la < 1) ? 1 : la;
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        last_stalls = 0; last_wb_addr = 32'hFFFF_FFFF; last_alloc_addr = 32'hFFFF_FFFF;
        addr = a; ren = r; wen = w; byte_select_vector = be; wdata = wd;
        mem_ready = 0; mem_rdata = '1;
        if (!hit) begin
            st_miss++;
            set_idle_exp(); exp_stall = 1;
            sample_and_step();
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], idx[5:0], 4'b0000};
                for (int k = 1; k <= nw; k++) begin
                    exp_stall = 1; exp_mwen = 1; exp_mren = 0; exp_maddr = vaddr; exp_mwdata = m_line[idx];
                    mem_ready = (k == nw);
                    sample_and_step();
                end
                mem_img[vaddr] = m_line[idx];
                m_dirty[idx] = 0;
                st_wb++;
            end
            for (int k = 1; k <= na; k++) begin
                exp_stall = 1; exp_mwen = 0; exp_mren = 1; exp_maddr = blk;
                mem_ready = (k == na);
                mem_rdata = (k == na) ? get_mem(blk) : '1;
                sample_and_step();
            end
            m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg; m_line[idx] = get_mem(blk);
            mem_ready = 0; mem_rdata = '1;
        end
        set_idle_exp();
        exp_rd_chk = 1;
        exp_rdata  = m_line[idx][wsel*32 +: 32];
        sample_and_step();
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_line[idx][wsel*32 + b*8 +: 8] = wd[b*8 +: 8];
            m_dirty[idx] = 1;
        end
        if (hit) st_hit++;
        ren = 0; wen = 0;
        set_idle_exp();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        st_hit = 0; st_miss = 0; st_wb = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; ren = 0; wen = 0; addr = 0; byte_select_vector = 0; wdata = 0;
        mem_ready = 0; mem_rdata = '0;
        model_reset();
        set_idle_exp();
        mem_img[32'h100] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_stall", stall, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1;
        chk_en = 1;
        @(posedge clock); #1;

        // cold load, memory answers on the third ALLOCATE cycle
        do_access(32'h100, 1, 0, 4'h0, 0, 0, 3);
        check("t1_stall_cycles", last_stalls, 4);
        check("t1_fill_addr", last_alloc_addr, 32'h100);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        do_access(32'h104, 1, 0, 4'h0, 0, 0, 1);
        check("t1_hit_stall_cycles", last_stalls, 0);

        // store hit to byte 1
        do_access(32'h100, 0, 1, 4'b0010, 32'h0000_AB00, 0, 1);
        check("t2_store_stall_cycles", last_stalls, 0);
        // mem_ready in IDLE with garbage data must be ignored
        mem_ready = 1; mem_rdata = {4{32'hBAD0_BAD0}};
        sample_and_step();
        mem_ready = 0; mem_rdata = '1;
        do_access(32'h100, 1, 0, 4'h0, 0, 0, 1);
        check("t2_rdata", last_rdata, 32'hDEAD_ABEF);

        // conflict miss evicts dirty line 0x100
        do_access(32'h500, 1, 0, 4'h0, 0, 2, 1);
        check("t3_wb_addr", last_wb_addr, 32'h100);
        check("t3_wb_word0", last_wb_line[31:0], 32'hDEAD_ABEF);
        check("t3_fill_addr", last_alloc_addr, 32'h500);
        check("t3_stall_cycles", last_stalls, 4);

        // store miss, single-cycle fill, then dirty eviction via 0x604
        do_access(32'h204, 0, 1, 4'hF, 32'h1234_5678, 0, 1);
        check("t4_stall_cycles", last_stalls, 2);
        check("t4_fill_addr", last_alloc_addr, 32'h200);
        do_access(32'h204, 1, 0, 4'h0, 0, 0, 1);
        check("t4_rdata", last_rdata, 32'h1234_5678);
        do_access(32'h604, 1, 0, 4'h0, 0, 1, 2);
        check("t4_wb_addr", last_wb_addr, 32'h200);
        check("t4_wb_word1", last_wb_line[63:32], 32'h1234_5678);
        check("t4_evict_stall_cycles", last_stalls, 4);

        // ren and wen together behave as a store
        do_access(32'h608, 1, 1, 4'b1001, 32'hA1B2_C3D4, 0, 1);
        do_access(32'h608, 1, 0, 4'h0, 0, 0, 1);

        // reset in the middle of ALLOCATE
        chk_en = 0;
        addr = 32'h300; ren = 1; wen = 0; mem_ready = 0;
        #1;
        check("t5_miss_stall", stall, 1);
        @(posedge clock); #1;
        check("t5_alloc_mem_ren", mem_ren, 1);
        check("t5_alloc_addr", mem_addr, 32'h300);
        reset = 0;
        #1;
        check("t5_async_mem_ren", mem_ren, 0);
        check("t5_async_mem_wen", mem_wen, 0);
        ren = 0;
        model_reset();
        @(posedge clock); #1;
        reset = 1;
        #1;
        check("t5_release_stall", stall, 0);
        check("t5_release_mem_ren", mem_ren, 0);
        set_idle_exp();
        chk_en = 1;
        do_access(32'h104, 1, 0, 4'h0, 0, 0, 2);
        check("t5_reload_stall_cycles", last_stalls, 3);
        check("t5_reload_addr", last_alloc_addr, 32'h100);
        check("t5_reload_rdata", last_rdata, 32'h1111_1111);

`ifdef DCACHE_STATS_EN
        #1;
        check("hit_count", hit_count, st_hit);
        check("miss_count", miss_count, st_miss);
        check("wb_count", wb_count, st_wb);
`endif

        @(posedge clock); #1;
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
